// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed four-digit seven-segment display driver. It takes the
// 16-bit BCD time word from the stopwatch core and scans it onto a shared
// segment bus with one anode enable per digit. The time word, the
// leading-zero enable and the decimal-point mask are captured into a shadow
// register once per frame, so a count update cannot tear a frame. Each digit
// slot starts with a few dark cycles so that ghosting between digits is
// suppressed.
//
// Parameters:
//   REFRESH_DIV    clk cycles per digit slot (>= 2)
//   BLANK_CYCLES   dark cycles at the start of each slot (1 .. REFRESH_DIV-1)
//   ACTIVE_LOW_SEG 1 inverts seg and dp at the pins (common-anode part)
//   ACTIVE_LOW_AN  1 inverts an at the pins
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   enable         0 forces the display dark and holds the scan at slot 0
//   time_data      four BCD digits, digit i = time_data[4i+3:4i], digit 0 rightmost
//   blank_leading  1 enables leading-zero suppression
//   dp_mask        dp_mask[i] lights the decimal point of digit i
//   seg            segments {g,f,e,d,c,b,a}, pin polarity
//   dp             decimal point, pin polarity
//   an             per-digit anode enables, pin polarity
//   frame_start    one-cycle pulse in the cycle after a new frame is latched
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 25000,
    parameter int BLANK_CYCLES   = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] time_data,
    input  logic        blank_leading,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    // Slot counter width; a two-cycle slot still needs one bit.
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Phase of the current digit slot.
    localparam logic [0:0] PHASE_BLANK = 1'b0;
    localparam logic [0:0] PHASE_ON    = 1'b1;

    // Logical segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan state
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;

    // Shadow copy of the inputs, refreshed once per frame
    logic [15:0]      sh_time;
    logic             sh_blank;
    logic [3:0]       sh_dp;

    // Registered logical (active-high) outputs before pin polarity
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;

    // Combinational decode of the current scan state
    logic             frame_latch;
    logic [0:0]       slot_phase;
    logic [3:0]       cur_digit;
    logic [3:0]       digit_zero;
    logic [3:0]       lead_blank;
    logic             cur_blanked;
    logic             cur_dp;
    logic [3:0]       cur_onehot;
    logic [6:0]       cur_pattern;
    logic [3:0]       next_an;
    logic [6:0]       next_seg;
    logic             next_dp;

    // BCD to seven-segment decode; anything that is not a decimal digit
    // shows a dash so a corrupted time word is visible instead of garbage.
    function automatic logic [6:0] decode_digit(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

    // A new frame is latched only at the very top of the scan, and only
    // while the driver is enabled. Because the counters are forced to zero
    // while disabled, the first enabled edge afterwards is always a latch.
    always_comb begin
        frame_latch = enable && (cnt == '0) && (idx == 2'd0);
    end

    // The first BLANK_CYCLES cycles of every slot are dark so the segment
    // bus can settle before the next anode turns on.
    always_comb begin
        slot_phase = (cnt < CNT_BLANK) ? PHASE_BLANK : PHASE_ON;
    end

    // Select the digit nibble and decimal point belonging to the slot
    // being scanned, and build the one-hot anode for it.
    always_comb begin
        cur_digit  = 4'd0;
        cur_dp     = 1'b0;
        cur_onehot = 4'b0000;
        case (idx)
            2'd0: begin
                cur_digit  = sh_time[3:0];
                cur_dp     = sh_dp[0];
                cur_onehot = 4'b0001;
            end
            2'd1: begin
                cur_digit  = sh_time[7:4];
                cur_dp     = sh_dp[1];
                cur_onehot = 4'b0010;
            end
            2'd2: begin
                cur_digit  = sh_time[11:8];
                cur_dp     = sh_dp[2];
                cur_onehot = 4'b0100;
            end
            default: begin
                cur_digit  = sh_time[15:12];
                cur_dp     = sh_dp[3];
                cur_onehot = 4'b1000;
            end
        endcase
        cur_pattern = decode_digit(cur_digit);
    end

    // Leading-zero suppression: a digit is blank when it and every digit to
    // its left are zero. The rightmost digit always shows, so an all-zero
    // time still reads "0" rather than a dark display.
    always_comb begin
        digit_zero[0] = (sh_time[3:0]   == 4'd0);
        digit_zero[1] = (sh_time[7:4]   == 4'd0);
        digit_zero[2] = (sh_time[11:8]  == 4'd0);
        digit_zero[3] = (sh_time[15:12] == 4'd0);

        lead_blank[3] = sh_blank && digit_zero[3];
        lead_blank[2] = lead_blank[3] && digit_zero[2];
        lead_blank[1] = lead_blank[2] && digit_zero[1];
        lead_blank[0] = 1'b0;

        cur_blanked   = lead_blank[idx];
    end

    // Next logical output values. During the ON phase exactly one anode is
    // driven. A suppressed digit keeps its segments off, but its anode is
    // still enabled when its decimal point is requested so a separator
    // such as the mm:ss colon stays visible.
    always_comb begin
        next_an  = 4'b0000;
        next_seg = SEG_OFF;
        next_dp  = 1'b0;
        if (enable && (slot_phase == PHASE_ON)) begin
            if (cur_blanked) begin
                if (cur_dp) begin
                    next_an = cur_onehot;
                    next_dp = 1'b1;
                end
            end else begin
                next_an  = cur_onehot;
                next_seg = cur_pattern;
                next_dp  = cur_dp;
            end
        end
    end

    // Scan counters. cnt walks through one digit slot, idx steps to the next
    // digit at the end of each slot and wraps after digit 3. Dropping enable
    // parks the scan at the top of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Shadow register. All three display inputs are captured together at
    // the frame latch and held for the whole frame, which is what keeps a
    // mid-frame count change from showing half old and half new digits.
    // The shadow keeps its value while the driver is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_time  <= 16'h0000;
            sh_blank <= 1'b0;
            sh_dp    <= 4'b0000;
        end else if (frame_latch) begin
            sh_time  <= time_data;
            sh_blank <= blank_leading;
            sh_dp    <= dp_mask;
        end
    end

    // Output registers. Everything seen at the pins is a registered decode
    // of the scan state from before the edge, so the pins lag the counters
    // by one cycle and are glitch-free. Reset darkens the display at once
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q        <= 4'b0000;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an_q        <= next_an;
            seg_q       <= next_seg;
            dp_q        <= next_dp;
            frame_start <= frame_latch;
        end
    end

    // Pin polarity. The inversion sits after the registers so that a
    // common-anode board sees all segments and anodes off during reset.
    always_comb begin
        seg = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
        dp  = ACTIVE_LOW_SEG ? ~dp_q  : dp_q;
        an  = ACTIVE_LOW_AN  ? ~an_q  : an_q;
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with REFRESH_DIV = 8 and
// BLANK_CYCLES = 2. Two instances share clock, reset and inputs: dut_hi uses
// active-high pins, dut_lo uses active-low segments and anodes. Stimulus
// pushes the expected per-cycle outputs, tagged with the cycle number they
// belong to, into a scoreboard queue; a monitor on the falling clock edge
// pops and compares whenever the current cycle matches the queue head.
// Expected digit patterns are written by hand in the stimulus calls.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] time_data;
    logic        blank_leading;
    logic [3:0]  dp_mask;

    logic [6:0]  seg_hi;
    logic        dp_hi;
    logic [3:0]  an_hi;
    logic        fs_hi;

    logic [6:0]  seg_lo;
    logic        dp_lo;
    logic [3:0]  an_lo;
    logic        fs_lo;

    int cyc;
    int tests_run;
    int tests_failed;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    seg7_scan_driver #(
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .ACTIVE_LOW_SEG (1'b0),
        .ACTIVE_LOW_AN  (1'b0)
    ) dut_hi (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .time_data     (time_data),
        .blank_leading (blank_leading),
        .dp_mask       (dp_mask),
        .seg           (seg_hi),
        .dp            (dp_hi),
        .an            (an_hi),
        .frame_start   (fs_hi)
    );

    seg7_scan_driver #(
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut_lo (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .time_data     (time_data),
        .blank_leading (blank_leading),
        .dp_mask       (dp_mask),
        .seg           (seg_lo),
        .dp            (dp_lo),
        .an            (an_lo),
        .frame_start   (fs_lo)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle number: count of rising edges seen so far
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Packs one digit slot's expected lit values {an, seg, dp}
    function automatic logic [11:0] slot(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    // Compares both instances against one scoreboard entry
    task automatic checkOutput(input exp_t e);
        tests_run++;
        if (an_hi !== e.an || seg_hi !== e.seg || dp_hi !== e.dp || fs_hi !== e.fs) begin
            tests_failed++;
            $display("[TB] FAIL hi_pins cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                     e.cyc, an_hi, seg_hi, dp_hi, fs_hi, e.an, e.seg, e.dp, e.fs);
        end
        tests_run++;
        if (an_lo !== ~e.an || seg_lo !== ~e.seg || dp_lo !== ~e.dp || fs_lo !== e.fs) begin
            tests_failed++;
            $display("[TB] FAIL lo_pins cyc=%0d got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                     e.cyc, an_lo, seg_lo, dp_lo, fs_lo, ~e.an, ~e.seg, ~e.dp, e.fs);
        end
    endtask

    // Monitor: consumes every entry whose cycle has arrived
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc < cyc) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL stale_entry cyc=%0d seen at cyc=%0d", mon_e.cyc, cyc);
            end else begin
                checkOutput(mon_e);
            end
        end
    end

    // Expect a dark display with no frame pulse for cycles first..last
    task automatic pushDark(input int first, input int last);
        exp_t e;
        for (int c = first; c <= last; c++) begin
            e.cyc = c;
            e.an  = 4'b0000;
            e.seg = 7'h00;
            e.dp  = 1'b0;
            e.fs  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Drives new display inputs and queues the expected frame that latches
    // them at cycle f. slots = {slot3, slot2, slot1, slot0}. Only the first
    // 'cut' cycles of the frame are queued (32 for a complete frame).
    task automatic applyStimulus(input int f, input int cut, input logic [15:0] td,
                                 input logic bl, input logic [3:0] dpm, input logic [47:0] slots);
        exp_t        e;
        logic [11:0] sl;
        time_data     = td;
        blank_leading = bl;
        dp_mask       = dpm;
        for (int o = 0; o < cut; o++) begin
            sl    = slots[12*(o/8) +: 12];
            e.cyc = f + o;
            e.fs  = (o == 0);
            if ((o % 8) < 2) begin
                e.an  = 4'b0000;
                e.seg = 7'h00;
                e.dp  = 1'b0;
            end else begin
                e.an  = sl[11:8];
                e.seg = sl[7:1];
                e.dp  = sl[0];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL watchdog run did not finish, cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus. Frames start every 32 cycles from cycle 4 until the
    // enable and reset tests change the schedule.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        reset         = 1'b1;
        enable        = 1'b1;
        time_data     = 16'h0000;
        blank_leading = 1'b0;
        dp_mask       = 4'b0000;

        // Reset state, then basic scan of 1234
        pushDark(1, 3);
        applyStimulus(4, 32, 16'h1234, 1'b0, 4'b0000,
            {slot(4'b1000, 7'h06, 1'b0), slot(4'b0100, 7'h5B, 1'b0),
             slot(4'b0010, 7'h4F, 1'b0), slot(4'b0001, 7'h66, 1'b0)});
        wait_cycle(3);
        reset = 1'b0;

        // 0959 latched; changed to 1000 in the middle of its frame
        wait_cycle(8);
        applyStimulus(36, 32, 16'h0959, 1'b0, 4'b0000,
            {slot(4'b1000, 7'h3F, 1'b0), slot(4'b0100, 7'h6F, 1'b0),
             slot(4'b0010, 7'h6D, 1'b0), slot(4'b0001, 7'h6F, 1'b0)});
        wait_cycle(46);
        applyStimulus(68, 32, 16'h1000, 1'b0, 4'b0000,
            {slot(4'b1000, 7'h06, 1'b0), slot(4'b0100, 7'h3F, 1'b0),
             slot(4'b0010, 7'h3F, 1'b0), slot(4'b0001, 7'h3F, 1'b0)});

        // Leading zeros with the colon decimal point on digit 2
        wait_cycle(72);
        applyStimulus(100, 32, 16'h0005, 1'b1, 4'b0100,
            {slot(4'b0000, 7'h00, 1'b0), slot(4'b0100, 7'h00, 1'b1),
             slot(4'b0000, 7'h00, 1'b0), slot(4'b0001, 7'h6D, 1'b0)});

        // All zeros with suppression: only digit 0 lit
        wait_cycle(104);
        applyStimulus(132, 32, 16'h0000, 1'b1, 4'b0000,
            {slot(4'b0000, 7'h00, 1'b0), slot(4'b0000, 7'h00, 1'b0),
             slot(4'b0000, 7'h00, 1'b0), slot(4'b0001, 7'h3F, 1'b0)});

        // Non-BCD digit shows a dash; decimal points on lit digits
        wait_cycle(136);
        applyStimulus(164, 32, 16'h00A0, 1'b0, 4'b1011,
            {slot(4'b1000, 7'h3F, 1'b1), slot(4'b0100, 7'h3F, 1'b0),
             slot(4'b0010, 7'h40, 1'b1), slot(4'b0001, 7'h3F, 1'b1)});

        // 0008: checked at both pin polarities
        wait_cycle(168);
        applyStimulus(196, 32, 16'h0008, 1'b0, 4'b0000,
            {slot(4'b1000, 7'h3F, 1'b0), slot(4'b0100, 7'h3F, 1'b0),
             slot(4'b0010, 7'h3F, 1'b0), slot(4'b0001, 7'h7F, 1'b0)});

        // A zero right of a nonzero digit is not suppressed; blanked digit 3 keeps its dp
        wait_cycle(200);
        applyStimulus(228, 32, 16'h0F0B, 1'b1, 4'b1000,
            {slot(4'b1000, 7'h00, 1'b1), slot(4'b0100, 7'h40, 1'b0),
             slot(4'b0010, 7'h3F, 1'b0), slot(4'b0001, 7'h40, 1'b0)});

        // Frame interrupted by enable=0 at idx=2, cnt=5
        wait_cycle(232);
        applyStimulus(260, 21, 16'h1234, 1'b0, 4'b0001,
            {slot(4'b1000, 7'h06, 1'b0), slot(4'b0100, 7'h5B, 1'b0),
             slot(4'b0010, 7'h4F, 1'b0), slot(4'b0001, 7'h66, 1'b1)});
        wait_cycle(280);
        enable = 1'b0;
        pushDark(281, 285);
        wait_cycle(282);
        applyStimulus(286, 12, 16'h0042, 1'b1, 4'b0000,
            {slot(4'b0000, 7'h00, 1'b0), slot(4'b0000, 7'h00, 1'b0),
             slot(4'b0010, 7'h66, 1'b0), slot(4'b0001, 7'h5B, 1'b0)});
        wait_cycle(285);
        enable = 1'b1;

        // Reset asserted just after an edge while digit 1 is lit
        wait_cycle(297);
        pushDark(298, 300);
        applyStimulus(301, 32, 16'h0008, 1'b0, 4'b0000,
            {slot(4'b1000, 7'h3F, 1'b0), slot(4'b0100, 7'h3F, 1'b0),
             slot(4'b0010, 7'h3F, 1'b0), slot(4'b0001, 7'h7F, 1'b0)});
        @(posedge clk);
        #1 reset = 1'b1;
        wait_cycle(300);
        reset = 1'b0;

        // Full frame with no leading zeros and every decimal point lit
        wait_cycle(305);
        applyStimulus(333, 32, 16'h9876, 1'b1, 4'b1111,
            {slot(4'b1000, 7'h6F, 1'b1), slot(4'b0100, 7'h7F, 1'b1),
             slot(4'b0010, 7'h07, 1'b1), slot(4'b0001, 7'h7D, 1'b1)});

        wait_cycle(366);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain got %0d entries left want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
